// File: rtl/verin_limit_switch_ctrl.sv
// ============================================================================
// verin_limit_switch_ctrl
// ----------------------------------------------------------------------------
// Avalon-MM slave that conditions the cylinder's end-of-travel / position
// switches for the Nios II driver. Each raw input goes through:
//   1. a 2-flop synchroniser,
//   2. a per-bit debouncer (IDLE/COUNT FSM with a CNT_W-bit counter),
//   3. an edge detector feeding a sticky EDGE_CAPTURE register (W1C),
//   4. a maskable level interrupt.
//
// Register map (word addresses, LSB-aligned, unused bits read 0):
//   0 DATA         RO  debounced switch state
//   1 IRQ_MASK     RW  per-bit interrupt enable
//   2 STATUS       RO  bit i = 1 while input i is being debounced (COUNT);
//                      bit 31 = 1 when both-edge capture is built in
//   3 EDGE_CAPTURE W1C latched edges; writing 1 clears, a same-cycle edge wins
//
// Build option:
//   VERIN_LSW_BOTH_EDGES_EN  defined   -> rising and falling edges captured
//                            undefined -> rising edges only (default)
//
// Parameters:
//   WIDTH            number of switch inputs (1..32)
//   DEBOUNCE_CYCLES  cycles an input must be stable before acceptance (>=2)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk         system clock
//   reset       synchronous reset, active-high; clears every state element
//   address     register select
//   chipselect  slave select
//   read        read strobe (1-cycle latency into readdata)
//   write       write strobe (takes effect at the sampling edge)
//   writedata   write data
//   readdata    registered read data, holds between reads
//   in_port     raw asynchronous switch inputs
//   irq         level interrupt, |(EDGE_CAPTURE & IRQ_MASK), from registers
// ============================================================================
module verin_limit_switch_ctrl #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Count value at which a persistent difference is accepted: entering
    // COUNT loads 1, so reaching DEBOUNCE_CYCLES-1 means DEBOUNCE_CYCLES
    // consecutive samples have disagreed with the debounced state.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef VERIN_LSW_BOTH_EDGES_EN
    localparam logic BOTH_EDGES = 1'b1;
`else
    localparam logic BOTH_EDGES = 1'b0;
`endif

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_EDGE   = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } db_state_t;

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    logic rd_en;
    logic wr_en;

    assign rd_en = chipselect & read;
    assign wr_en = chipselect & write;

    // Only writedata[WIDTH-1:0] carries meaning; fold the rest away so the
    // unused upper bits do not look like a mistake.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata};

    // ------------------------------------------------------------------------
    // Synchroniser: two flops per bit, cleared by reset
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
        end
    end

    // ------------------------------------------------------------------------
    // Per-bit debouncers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] db_vec;       // debounced state, one bit per input
    logic [WIDTH-1:0] status_vec;   // 1 while the bit's FSM is in COUNT

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
            db_state_t        state_reg;
            db_state_t        state_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             db_reg;
            logic             db_next;
            logic             in_count;

            // State register
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    db_reg    <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    db_reg    <= db_next;
                end
            end

            // Next-state logic
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                db_next    = db_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (sync2_reg[gi] != db_reg) begin
                            state_next = ST_COUNT;
                            cnt_next   = CNT_ONE;
                        end
                    end
                    ST_COUNT: begin
                        if (sync2_reg[gi] == db_reg) begin
                            // Input fell back before the window elapsed:
                            // treat it as a bounce and forget it.
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            db_next    = sync2_reg[gi];
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end else if (cnt_reg != {CNT_W{1'b1}}) begin
                            // Saturating guard: acceptance at CNT_LAST means
                            // the counter never needs to wrap.
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            // Output logic
            always_comb begin
                in_count = (state_reg == ST_COUNT);
            end

            assign db_vec[gi]     = db_reg;
            assign status_vec[gi] = in_count;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Edge detection and capture
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] db_prev_reg;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edge_cap_reg;
    logic [WIDTH-1:0] edge_cap_next;
    logic [WIDTH-1:0] irq_mask_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            db_prev_reg <= '0;
        end else begin
            db_prev_reg <= db_vec;
        end
    end

`ifdef VERIN_LSW_BOTH_EDGES_EN
    assign edge_pulse = db_vec ^ db_prev_reg;
`else
    assign edge_pulse = db_vec & ~db_prev_reg;
`endif

    assign edge_clr = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    // Clear first, then OR in new pulses so a coincident edge is never lost.
    assign edge_cap_next = (edge_cap_reg & ~edge_clr) | edge_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cap_reg <= '0;
            irq_mask_reg <= '0;
        end else begin
            edge_cap_reg <= edge_cap_next;
            if (wr_en && (address == ADDR_MASK)) begin
                irq_mask_reg <= writedata[WIDTH-1:0];
            end
        end
    end

    // Interrupt is a pure function of two registers; nothing on the bus can
    // reach it combinationally.
    assign irq = |(edge_cap_reg & irq_mask_reg);

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:   rd_mux[WIDTH-1:0] = db_vec;
            ADDR_MASK:   rd_mux[WIDTH-1:0] = irq_mask_reg;
            ADDR_STATUS: begin
                rd_mux[WIDTH-1:0] = status_vec;
                rd_mux[31]        = BOTH_EDGES;
            end
            default:     rd_mux[WIDTH-1:0] = edge_cap_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_verin_limit_switch_ctrl.sv
// ============================================================================
// tb_verin_limit_switch_ctrl
// Directed scenarios followed by randomized traffic. A reference model of the
// register file runs alongside the DUT: the debounced value of a bit changes
// once the last DEBOUNCE_CYCLES synchronised samples all disagree with it, and
// a bit is "counting" while its latest synchronised sample disagrees.
// ============================================================================
module tb_verin_limit_switch_ctrl;

    localparam int W = 3;
    localparam int D = 4;

`ifdef VERIN_LSW_BOTH_EDGES_EN
    localparam bit BOTH = 1'b1;
`else
    localparam bit BOTH = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic [1:0]    address    = 2'd0;
    logic          chipselect = 1'b0;
    logic          read       = 1'b0;
    logic          write      = 1'b0;
    logic [31:0]   writedata  = 32'd0;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port    = '0;
    logic          irq;

    int checks = 0;
    int errors = 0;

    verin_limit_switch_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    logic [W-1:0] m_db     = '0;
    logic [W-1:0] m_dbprev = '0;
    logic [W-1:0] m_mask   = '0;
    logic [W-1:0] m_ec     = '0;
    logic [31:0]  m_rd     = '0;
    logic [W-1:0] m_in_q[$];    // raw in_port samples, one per edge
    logic [W-1:0] m_seen_q[$];  // synchronised values seen by the debouncer

    function automatic logic [W-1:0] m_status();
        logic [W-1:0] s;
        s = '0;
        if (m_seen_q.size() > 0) s = m_seen_q[m_seen_q.size()-1] ^ m_db;
        return s;
    endfunction

    task automatic model_edge();
        logic [W-1:0] pulse;
        logic [W-1:0] clr;
        logic [W-1:0] s2;
        logic [31:0]  mux;
        bit           all_diff;
        if (reset) begin
            m_db = '0; m_dbprev = '0; m_mask = '0; m_ec = '0; m_rd = '0;
            m_in_q.delete();
            m_seen_q.delete();
            return;
        end
        mux = '0;
        case (address)
            2'd0: mux[W-1:0] = m_db;
            2'd1: mux[W-1:0] = m_mask;
            2'd2: begin mux[W-1:0] = m_status(); mux[31] = BOTH; end
            default: mux[W-1:0] = m_ec;
        endcase
        pulse = BOTH ? (m_db ^ m_dbprev) : (m_db & ~m_dbprev);
        clr   = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
        m_ec  = (m_ec & ~clr) | pulse;
        if (chipselect && write && address == 2'd1) m_mask = writedata[W-1:0];
        if (chipselect && read) m_rd = mux;
        m_dbprev = m_db;
        // Two flops of delay: the value seen now was sampled two edges ago.
        s2 = (m_in_q.size() >= 2) ? m_in_q[m_in_q.size()-2] : '0;
        m_in_q.push_back(in_port);
        m_seen_q.push_back(s2);
        if (m_seen_q.size() >= D) begin
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= D; k++) begin
                    if (m_seen_q[m_seen_q.size()-k][b] == m_db[b]) all_diff = 1'b0;
                end
                if (all_diff) m_db[b] = ~m_db[b];
            end
        end
        while (m_in_q.size() > 16)   void'(m_in_q.pop_front());
        while (m_seen_q.size() > 16) void'(m_seen_q.pop_front());
    endtask

    // ------------------------------------------------------------------------
    // Checking and bus helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("readdata", readdata, m_rd);
        chk("irq", {31'd0, irq}, {31'd0, |(m_ec & m_mask)});
    endtask

    task automatic do_read(input logic [1:0] a);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        $display("t=%0t read  addr=%0d data=%h irq=%0b", $time, a, readdata, irq);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
        $display("t=%0t write addr=%0d data=%h irq=%0b", $time, a, d, irq);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        bit saw_status;

        // Reset state with all inputs held high through reset
        in_port = 3'b111;
        apply_reset(3);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        do_read(2'd2); chk("rst_status", readdata, {BOTH, 31'd0});
        do_read(2'd0); chk("rst_data", readdata, 32'd0);
        do_read(2'd1); chk("rst_mask", readdata, 32'd0);
        do_read(2'd3); chk("rst_edge", readdata, 32'd0);
        tick();
        do_read(2'd0); chk("data_before_accept", readdata, 32'd0);
        do_read(2'd0); chk("data_after_accept", readdata, 32'd7);

        // Glitch rejection: bit 0 high for 3 sampled cycles only
        in_port = '0;
        apply_reset(2);
        repeat (3) tick();
        saw_status = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_port[0] = (i < 3);
            do_read(2'd2);
            saw_status |= readdata[0];
        end
        chk("glitch_status_seen", {31'd0, saw_status}, 32'd1);
        chk("glitch_status_end", readdata, {BOTH, 31'd0});
        do_read(2'd0); chk("glitch_data", readdata, 32'd0);
        do_read(2'd3); chk("glitch_edge", readdata, 32'd0);

        // Accepted edge with interrupt on bit 1
        do_write(2'd1, 32'h2);
        in_port[1] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            if (c == 7) begin chipselect = 1'b1; read = 1'b1; address = 2'd0; end
            if (c == 8) begin chipselect = 1'b1; read = 1'b1; address = 2'd3; end
            tick();
            chipselect = 1'b0; read = 1'b0;
            if (c == 6) chk("irq_before_edge", {31'd0, irq}, 32'd0);
            if (c == 7) begin
                chk("data_bit1", readdata, 32'h2);
                chk("irq_on_edge", {31'd0, irq}, 32'd1);
            end
            if (c == 8) chk("edge_bit1", readdata, 32'h2);
            $display("t=%0t cycle %0d in=%b irq=%0b", $time, c, in_port, irq);
        end
        do_write(2'd3, 32'h2);
        chk("irq_after_w1c", {31'd0, irq}, 32'd0);

        // Set-wins race on bit 2
        in_port[2] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (c == 7) begin chipselect = 1'b1; write = 1'b1; address = 2'd3; writedata = 32'h4; end
            if (c == 8) begin chipselect = 1'b1; read = 1'b1; address = 2'd3; end
            tick();
            chipselect = 1'b0; read = 1'b0; write = 1'b0;
            $display("t=%0t race cycle %0d readdata=%h", $time, c, readdata);
        end
        chk("set_wins", readdata, 32'h4);

        // Falling edge on bit 1
        do_write(2'd3, 32'h7);
        in_port[1] = 1'b0;
        repeat (10) tick();
        do_read(2'd3); chk("fall_edge", readdata, BOTH ? 32'h2 : 32'h0);
        chk("fall_irq", {31'd0, irq}, BOTH ? 32'd1 : 32'd0);
        do_read(2'd2); chk("fall_status", readdata, {BOTH, 31'd0});
        do_read(2'd0); chk("fall_data", readdata, 32'h4);

        // Reset in the middle of a count on bit 0
        in_port = '0;
        apply_reset(2);
        repeat (4) tick();
        in_port[0] = 1'b1;
        repeat (3) tick();
        do_read(2'd2); chk("midcount_status", readdata, {BOTH, 31'd1});
        apply_reset(1);
        do_read(2'd2); chk("post_reset_status", readdata, {BOTH, 31'd0});
        repeat (4) tick();
        do_read(2'd0); chk("midcount_data_early", readdata, 32'd0);
        do_read(2'd0); chk("midcount_data", readdata, 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 7) == 0) in_port = W'($urandom);
            if (r < 30)       do_read(2'($urandom));
            else if (r < 42)  do_write(2'($urandom), $urandom);
            else if (r == 42) begin apply_reset(1); $display("t=%0t reset pulse", $time); end
            else begin tick(); $display("t=%0t idle in=%b irq=%0b", $time, in_port, irq); end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/verin_limit_switch_ctrl.md
# verin_limit_switch_ctrl

Avalon-MM slave controller for the cylinder's 3 end-of-travel/position switch inputs. It replaces a raw input PIO in the cylinder-management subsystem with four stages: synchronisation, per-bit debounce, edge capture and a maskable interrupt. The Nios II driver sees stable switch states and latched transitions instead of polling bouncing contacts.

## Interface
- `WIDTH`, 3, number of switch inputs (1..32)
- `DEBOUNCE_CYCLES`, 50000, clock cycles an input must stay stable before it is accepted (≥2; 1 ms at 50 MHz)
- `CNT_W`, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
- `clk`  in  1  system clock
- `reset`  in  1  synchronous reset, active-high
- `address`  in  2  register select
- `chipselect`  in  1  slave select
- `read`  in  1  read strobe
- `write`  in  1  write strobe
- `writedata`  in  32  write data
- `readdata`  out  32  registered read data
- `in_port`  in  WIDTH  raw asynchronous switch inputs
- `irq`  out  1  level interrupt to CPU

## Operation
- Register map, LSB-aligned, unused bits read 0:
  - 0 DATA (RO): debounced state.
  - 1 IRQ_MASK (RW).
  - 2 STATUS (RO): bit i = 1 while input i's debouncer is in COUNT.
  - 3 EDGE_CAPTURE (W1C).
- Writes to RO registers are ignored.
- Synchroniser: 2 flops per bit, reset to 0.
- Debouncer per bit. Two states, IDLE and COUNT; counter `cnt` is CNT_W bits.
  - IDLE, with sync ≠ db: go to COUNT, cnt←1.
  - COUNT, with sync = db: return to IDLE, cnt←0 (the glitch is discarded).
  - COUNT, with sync ≠ db and cnt = DEBOUNCE_CYCLES−1: db←sync, go to IDLE, cnt←0.
  - COUNT, any other case: cnt←cnt+1.
  - The counter never wraps.
- Edge detect: a pulse is generated when db_prev=0 and db=1 (rising edge). Both-edge behaviour is covered under Configuration.
- EDGE_CAPTURE bit i is set by an edge pulse.
  - Cleared by a write to address 3 with `writedata[i]`=1.
  - If the clear and the edge pulse occur in the same cycle, set wins.
- `irq` = |(EDGE_CAPTURE & IRQ_MASK). It is driven from registers only, with no combinational path from the bus.
- Reset: every state element goes to 0.
  - Covers sync flops, db, db_prev, cnt, FSMs (IDLE), IRQ_MASK, EDGE_CAPTURE, `readdata` and `irq`.
  - Reset mid-count aborts the count.
  - An input held high through reset is accepted as a fresh rising edge DEBOUNCE_CYCLES+2 cycles after reset deasserts.

## Timing
- Read latency is 1 cycle. `readdata` is updated on the edge after `chipselect & read` and holds between reads.
- Writes take effect at the clock edge where `chipselect & write` is sampled.
- Input step to DATA:
  - A step on `in_port` that is stable from edge k appears in db at edge k+2+DEBOUNCE_CYCLES.
  - The EDGE_CAPTURE bit sets on the next edge.
  - `irq` asserts in that same cycle if the bit is masked in.
- All WIDTH bits are independent. Simultaneous transitions on several bits are each debounced and captured separately.

## Configuration
- `VERIN_LSW_BOTH_EDGES_EN` defined:
  - The edge pulse is db_prev ≠ db, so both rising and falling transitions set EDGE_CAPTURE.
  - STATUS bit 31 reads 1.
- Not defined:
  - Rising edges only.
  - STATUS bit 31 reads 0.

## Test plan
Bench parameters: WIDTH=3, DEBOUNCE_CYCLES=4.
- Reset state: assert reset with `in_port`=3'b111, then read addresses 0–3.
  - Required: all reads return 0 and `irq`=0.
  - DATA reads 3'b111 at cycle 6 after release.
- Glitch rejection: `in_port[0]` high for 3 cycles, then low.
  - Required: DATA stays 0 and EDGE_CAPTURE stays 0.
  - STATUS[0]=1 only during the glitch window.
- Accepted edge with IRQ: write IRQ_MASK=3'b010, then hold `in_port[1]` high for 10 cycles.
  - Required: DATA=3'b010 at cycle 6, EDGE_CAPTURE=3'b010 and `irq`=1 at cycle 7.
  - Then write 3'b010 to address 3: `irq`=0 on the next cycle.
- Set-wins race: issue the W1C of bit 2 in the same cycle that bit 2's edge pulse fires.
  - Required: EDGE_CAPTURE[2] remains 1.
- Falling edge:
  - With the macro undefined: drop `in_port[1]` from 1 to 0; EDGE_CAPTURE stays 0.
  - With `VERIN_LSW_BOTH_EDGES_EN`: EDGE_CAPTURE[1] becomes 1 and STATUS[31]=1.
- Reset mid-count: assert reset 2 cycles into COUNT on bit 0.
  - Required: cnt and STATUS cleared.
  - With the input still high, DATA[0]=1 exactly 6 cycles after release.
